// File: rtl/pwm_peripheral.sv
// Shared 8-bit PWM generator driving 16 output pins from the SPI register bytes.
// Define PWM_DUTY_SHADOW_EN to latch duty changes only at PWM period boundaries.
module pwm_peripheral #(
  parameter int CLK_DIV = 3000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] en_reg_out_7_0,
  input  logic [7:0] en_reg_out_15_8,
  input  logic [7:0] en_reg_pwm_7_0,
  input  logic [7:0] en_reg_pwm_15_8,
  input  logic [7:0] pwm_duty_cycle,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic       period_start
);

  localparam logic [15:0] DIV_MAX = 16'(CLK_DIV - 1);
  localparam logic [7:0]  CNT_MAX = 8'd254;

  logic [15:0] presc;
  logic [7:0]  pwm_cnt;
  logic [7:0]  duty_eff;
  logic        tick;
  logic        wrap;
  logic        pwm_level;

  assign tick = (presc == DIV_MAX);
  assign wrap = tick && (pwm_cnt == CNT_MAX);

  // The counter stops at 254 so that a duty of 0xFF holds the level high all period.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc        <= '0;
      pwm_cnt      <= '0;
      period_start <= 1'b0;
    end else begin
      presc        <= tick ? 16'd0 : presc + 16'd1;
      if (tick)
        pwm_cnt    <= wrap ? 8'd0 : pwm_cnt + 8'd1;
      period_start <= wrap;
    end
  end

`ifdef PWM_DUTY_SHADOW_EN
  logic [7:0] duty_shadow;

  always_ff @(posedge clk) begin
    if (rst)
      duty_shadow <= 8'h00;
    else if (wrap)
      duty_shadow <= pwm_duty_cycle;
  end

  assign duty_eff = duty_shadow;
`else
  assign duty_eff = pwm_duty_cycle;
`endif

  assign pwm_level = (pwm_cnt < duty_eff);

  always_ff @(posedge clk) begin
    if (rst) begin
      uo_out  <= 8'h00;
      uio_out <= 8'h00;
    end else begin
      uo_out  <= en_reg_out_7_0  & (~en_reg_pwm_7_0  | {8{pwm_level}});
      uio_out <= en_reg_out_15_8 & (~en_reg_pwm_15_8 | {8{pwm_level}});
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed scoreboard bench for pwm_peripheral with CLK_DIV = 4 (1020-cycle period).
// Expectations follow PWM_DUTY_SHADOW_EN the same way the design does.
module tb_pwm_peripheral;

  localparam int CLK_DIV = 4;
  localparam int PERIOD  = 255 * CLK_DIV;

  logic       clk;
  logic       rst;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic       period_start;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .uo_out          (uo_out),
    .uio_out         (uio_out),
    .period_start    (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_expected(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_output(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%0d required=an expected entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%0d required=%0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic wait_ps(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      step(1);
      if (period_start) begin
        n = i;
        break;
      end
    end
  endtask

  // Samples one full period starting just after a period_start sample.
  task automatic measure(output int highs, output int pulses, output int last_ps);
    highs  = 0;
    pulses = 0;
    for (int i = 1; i <= PERIOD; i++) begin
      step(1);
      if (uio_out[0]) highs++;
      if (period_start) pulses++;
    end
    last_ps = int'(period_start);
  endtask

  task automatic run_period(input logic [7:0] duty, input string tag, input int exp_highs);
    int n, highs, pulses, last_ps;
    pwm_duty_cycle = duty;
    wait_ps(PERIOD + 80, n);
    push_expected({tag, "_period_len"}, PERIOD);
    check_output(n);
    measure(highs, pulses, last_ps);
    push_expected({tag, "_high_cycles"}, exp_highs);
    check_output(highs);
  endtask

  initial begin
    int n, highs, pulses, last_ps;
    int pin400, pin401;

    rst             = 1'b1;
    en_reg_out_7_0  = 8'hFF;
    en_reg_out_15_8 = 8'hFF;
    en_reg_pwm_7_0  = 8'hFF;
    en_reg_pwm_15_8 = 8'hFF;
    pwm_duty_cycle  = 8'hFF;

    for (int i = 0; i < 3; i++) begin
      step(1);
      push_expected("reset_outputs", 32'h0);
      check_output(32'({uo_out, uio_out, period_start}));
    end

    en_reg_out_7_0  = 8'h00;
    en_reg_out_15_8 = 8'h00;
    en_reg_pwm_7_0  = 8'h00;
    en_reg_pwm_15_8 = 8'h00;
    pwm_duty_cycle  = 8'h00;
    rst             = 1'b0;
    step(2);

    en_reg_out_7_0  = 8'hA5;
    en_reg_out_15_8 = 8'h3C;
    push_expected("static_before_edge", 32'h0000);
    check_output(32'({uo_out, uio_out}));
    step(1);
    push_expected("static_drive", 32'hA53C);
    check_output(32'({uo_out, uio_out}));

    en_reg_out_15_8 = 8'h01;
    en_reg_pwm_15_8 = 8'h01;
    pwm_duty_cycle  = 8'h80;
    wait_ps(PERIOD + 80, n);
    push_expected("first_period_start_seen", 32'd1);
    check_output(32'(period_start));
    measure(highs, pulses, last_ps);
    push_expected("ratio_high_cycles", 32'd512);
    check_output(highs);
    push_expected("ratio_pulse_count", 32'd1);
    check_output(pulses);
    push_expected("ratio_pulse_at_period_end", 32'd1);
    check_output(last_ps);

    run_period(8'h00, "duty00", 0);
    run_period(8'hFF, "dutyFF", PERIOD);
    en_reg_out_15_8 = 8'h00;
    run_period(8'hFF, "pwm_without_oe", 0);
    en_reg_out_15_8 = 8'h01;

    run_period(8'h40, "duty40", 256);
    highs  = 0;
    pin400 = 0;
    pin401 = 0;
    for (int i = 1; i <= PERIOD; i++) begin
      step(1);
      if (uio_out[0]) highs++;
      if (i == 400) begin
        pin400 = int'(uio_out[0]);
        pwm_duty_cycle = 8'hC0;
      end
      if (i == 401) pin401 = int'(uio_out[0]);
    end
    push_expected("mid_change_pin_at_cnt100", 32'd0);
    check_output(pin400);
    push_expected("mid_change_period_end", 32'd1);
    check_output(32'(period_start));
`ifdef PWM_DUTY_SHADOW_EN
    push_expected("mid_change_pin_next_cycle", 32'd0);
    check_output(pin401);
    push_expected("mid_change_current_period", 32'd256);
    check_output(highs);
`else
    push_expected("mid_change_pin_next_cycle", 32'd1);
    check_output(pin401);
    push_expected("mid_change_current_period", 32'd624);
    check_output(highs);
`endif
    measure(highs, pulses, last_ps);
    push_expected("mid_change_next_period", 32'd768);
    check_output(highs);

    step(600);
    push_expected("pin_high_at_cnt150", 32'd1);
    check_output(32'(uio_out[0]));
    rst = 1'b1;
    step(1);
    push_expected("mid_reset_outputs", 32'h0);
    check_output(32'({uo_out, uio_out, period_start}));
    rst = 1'b0;
    wait_ps(PERIOD + 80, n);
    push_expected("first_ps_after_reset", PERIOD);
    check_output(n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
